boundary_ctrl: RTL
==================

# boundary_ctrl

Sequencer that sits in front of `boundary_select` and behind the corner/marker detector. It collects the four corner reports for a frame and drives them onto `boundary_select`. After a settle window it latches the resulting draw box and scale, then validates them. It then walks the draw box pixel by pixel over a valid/ready stream, emitting destination coordinates and scaled source coordinates for the blitter.

## Interface
Parameters:
- `p_image_width`, 80, destination width in pixels; box must satisfy end_x < this.
- `p_image_height`, 480, destination height in pixels; box must satisfy end_y < this.
- `p_settle`, 2, cycles (≥1) to wait after the last corner before sampling `boundary_select` outputs.

Ports (clock and reset first):
- `clk`  in  1  single system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `frame_start`  in  1  one-cycle pulse; aborts any activity, clears corners.
- `corner_valid`  in  1  corner report valid.
- `corner_ready`  out  1  = (state==COLLECT) & ~frame_start.
- `corner_id`  in  2  0=top-left, 1=top-right, 2=bot-left, 3=bot-right.
- `corner_x`, `corner_y`  in  11 each  reported coordinate.
- `top_left_x/y`, `top_right_x/y`, `bot_left_x/y`, `bot_right_x/y`  out  11 each  registered corners to `boundary_select`.
- `draw_start_x/y`, `draw_end_x/y`  in  11 each  from `boundary_select`.
- `scale`  in  8  from `boundary_select`, unsigned 4.4 fixed point (16 = 1.0).
- `pix_valid`  out  1  pixel output valid.
- `pix_ready`  in  1  downstream accepts pixel.
- `pix_x`, `pix_y`  out  11 each  destination coordinate.
- `src_x`, `src_y`  out  11 each  source coordinate.
- `pix_last`  out  1  with pix_valid on final pixel of box.
- `busy`  out  1  state != COLLECT.
- `frame_done`  out  1  one-cycle pulse after last pixel accepted.
- `error`  out  1  one-cycle pulse on rejected box.

## Operation
- States: COLLECT, SETTLE, CHECK, SCAN, DONE. Reset → COLLECT. All registered outputs and corner registers are 0, and `seen` = 4'b0000. `corner_ready` is 1 after reset.
- COLLECT: on corner_valid & corner_ready, write corner_x/y to the register selected by corner_id and set `seen[corner_id]`. A repeat id overwrites. When the accept makes seen==4'hF, go to SETTLE with counter = p_settle.
- SETTLE: corner inputs ignored. Decrement each cycle; on the final cycle latch draw_start/end and scale into internal box registers, then go to CHECK.
- CHECK (1 cycle): reject if end_x<start_x, end_y<start_y, scale==0, end_x≥p_image_width, or end_y≥p_image_height. On reject: pulse error, clear seen, return to COLLECT. Otherwise load pix_x=start_x, pix_y=start_y, acc_x=acc_y=0, and go to SCAN.
- SCAN: pix_valid=1; outputs hold stable while pix_ready=0. On handshake:
  - x≠end_x: pix_x+1, acc_x+=scale.
  - x==end_x, y≠end_y: pix_x=start_x, acc_x=0, pix_y+1, acc_y+=scale.
  - x==end_x and y==end_y (pix_last=1): go to DONE.
- Accumulators: 18-bit unsigned, wrap on overflow. src_x=acc_x[14:4], src_y=acc_y[14:4] (floor of the 4.4 product).
- DONE (1 cycle): pulse frame_done, clear seen, go to COLLECT. Corner registers keep their values.
- frame_start in any state (highest priority): next state COLLECT, seen cleared, pix_valid low next cycle. No corner is accepted in that cycle. frame_start in SETTLE/CHECK suppresses the error pulse.

## Timing
- The accept edge of the 4th corner → pix_valid high p_settle+1 edges later (3 with defaults).
- Corner outputs update on the edge following the accept.
- Sustained throughput: 1 pixel/cycle when pix_ready is held high. A box of W×H pixels takes W·H handshakes.
- The last handshake edge → frame_done high for the following cycle; corner_ready returns one cycle after that.
- Reset assertion mid-SCAN drops pix_valid, busy, frame_done and error immediately (asynchronously).

## Test plan
- Corners TL(10,20) TR(12,20) BL(10,21) BR(12,21) sent in order 3,0,2,1. Model returns start(10,20), end(12,21), scale 16. Expect 6 pixels in row-major order (10,20)…(12,21), src (0,0)…(2,1), and pix_last only on (12,21). Expect a frame_done pulse.
- Same box, scale 8. Expect src_x sequence 0,0,1 on each row and src_y 0 then 0. Toggle pix_ready 1/0 every cycle and check the outputs hold while stalled.
- Model returns end_x=80 with p_image_width=80. Expect an error pulse 3 edges after the 4th corner, no pix_valid, and corner_ready high again.
- Send id 0 twice (5,5) then (7,7), plus ids 1–3. Expect top_left=(7,7) and SETTLE entered only after all 4 ids are seen.
- Assert frame_start mid-SCAN and in the same cycle as a corner_valid. Expect pix_valid low next cycle, corner_ready=0 that cycle, and the corner not captured (seen==0).
- Assert reset low during SCAN. Expect all outputs 0 asynchronously and corner_ready=1 after release.

Source files
------------

// File: rtl/boundary_ctrl_if.sv
// boundary_ctrl_if
// Pixel stream from boundary_ctrl to the blitter.
//   pix_valid  : a destination/source coordinate pair is presented
//   pix_ready  : blitter accepts the current pair
//   pix_x/y    : destination coordinate inside the draw box
//   src_x/y    : source coordinate, destination offset scaled by the 4.4 scale
//   pix_last   : final pixel of the box, qualified by pix_valid
// master = sequencer side, slave = blitter side.
interface boundary_ctrl_if;
  logic        pix_valid;
  logic        pix_ready;
  logic [10:0] pix_x;
  logic [10:0] pix_y;
  logic [10:0] src_x;
  logic [10:0] src_y;
  logic        pix_last;

  modport master (
    output pix_valid, pix_x, pix_y, src_x, src_y, pix_last,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_x, pix_y, src_x, src_y, pix_last,
    output pix_ready
  );
endinterface

// File: rtl/boundary_ctrl.sv
// boundary_ctrl
// Collects the four corner reports of a frame, presents them to
// boundary_select, waits a settle window, latches and validates the returned
// draw box and scale, then walks the box row-major over the pixel stream.
// Ports:
//   clk, reset (async, active low)
//   frame_start                 : aborts activity, clears collected corners
//   corner_valid/ready/id/x/y   : corner report handshake
//   top_left_x .. bot_right_y   : registered corners to boundary_select
//   draw_start_x .. draw_end_y  : draw box from boundary_select
//   scale                       : 4.4 scale from boundary_select
//   pix                         : pixel stream (master side)
//   busy, frame_done, error     : status
module boundary_ctrl #(
  parameter int p_image_width  = 80,
  parameter int p_image_height = 480,
  parameter int p_settle       = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        corner_valid,
  output logic        corner_ready,
  input  logic [1:0]  corner_id,
  input  logic [10:0] corner_x,
  input  logic [10:0] corner_y,
  output logic [10:0] top_left_x,
  output logic [10:0] top_left_y,
  output logic [10:0] top_right_x,
  output logic [10:0] top_right_y,
  output logic [10:0] bot_left_x,
  output logic [10:0] bot_left_y,
  output logic [10:0] bot_right_x,
  output logic [10:0] bot_right_y,
  input  logic [10:0] draw_start_x,
  input  logic [10:0] draw_start_y,
  input  logic [10:0] draw_end_x,
  input  logic [10:0] draw_end_y,
  input  logic [7:0]  scale,
  boundary_ctrl_if.master pix,
  output logic        busy,
  output logic        frame_done,
  output logic        error
);

  typedef enum logic [2:0] {COLLECT, SETTLE, CHECK, SCAN, DONE} state_t;

  localparam int              c_cnt_w       = $clog2(p_settle + 1);
  localparam logic [c_cnt_w-1:0] c_settle_load = c_cnt_w'(p_settle);
  localparam logic [10:0]     c_max_x       = 11'(p_image_width);
  localparam logic [10:0]     c_max_y       = 11'(p_image_height);

  state_t              state, state_next;
  logic [3:0]          seen;
  logic [3:0]          id_onehot;
  logic [c_cnt_w-1:0]  settle_cnt;
  logic [10:0]         box_sx, box_sy, box_ex, box_ey;
  logic [7:0]          box_scale;
  logic [10:0]         pix_x_q, pix_y_q;
  logic [17:0]         acc_x, acc_y;
  logic                accept, corners_complete, settle_final, reject, last_pix;
  logic                pix_valid_c, pix_last_c;
  logic [13:0]         acc_unused_bits;

  assign id_onehot        = 4'b0001 << corner_id;
  assign accept           = corner_valid & corner_ready;
  assign corners_complete = (seen | id_onehot) == 4'hF;
  assign settle_final     = settle_cnt == c_cnt_w'(1);
  assign reject           = (box_ex < box_sx) | (box_ey < box_sy) | (box_scale == 8'd0)
                          | (box_ex >= c_max_x) | (box_ey >= c_max_y);
  assign last_pix         = (pix_x_q == box_ex) & (pix_y_q == box_ey);

  // Source coordinate is the floor of the 4.4 accumulator; the integer
  // part above bit 14 and the fraction are intentionally dropped.
  assign pix.pix_valid = pix_valid_c;
  assign pix.pix_last  = pix_last_c;
  assign pix.pix_x     = pix_x_q;
  assign pix.pix_y     = pix_y_q;
  assign pix.src_x     = acc_x[14:4];
  assign pix.src_y     = acc_y[14:4];
  assign acc_unused_bits = {acc_x[17:15], acc_x[3:0], acc_y[17:15], acc_y[3:0]};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= COLLECT;
    else        state <= state_next;
  end

  // Next-state logic; frame_start overrides everything
  always_comb begin
    state_next = state;
    if (frame_start) begin
      state_next = COLLECT;
    end else begin
      case (state)
        COLLECT: if (accept && corners_complete) state_next = SETTLE;
        SETTLE:  if (settle_final) state_next = CHECK;
        CHECK:   state_next = reject ? COLLECT : SCAN;
        SCAN:    if (pix.pix_ready && last_pix) state_next = DONE;
        DONE:    state_next = COLLECT;
        default: state_next = COLLECT;
      endcase
    end
  end

  // Outputs decoded from the state
  always_comb begin
    corner_ready = (state == COLLECT) & ~frame_start;
    busy         = (state != COLLECT);
    frame_done   = (state == DONE);
    pix_valid_c  = (state == SCAN);
    pix_last_c   = (state == SCAN) & last_pix;
  end

  // Datapath: corner capture, settle count, box latch and the pixel walk.
  // error is a registered pulse so it lands in the first COLLECT cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seen        <= '0;
      settle_cnt  <= '0;
      top_left_x  <= '0;
      top_left_y  <= '0;
      top_right_x <= '0;
      top_right_y <= '0;
      bot_left_x  <= '0;
      bot_left_y  <= '0;
      bot_right_x <= '0;
      bot_right_y <= '0;
      box_sx      <= '0;
      box_sy      <= '0;
      box_ex      <= '0;
      box_ey      <= '0;
      box_scale   <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      acc_x       <= '0;
      acc_y       <= '0;
      error       <= 1'b0;
    end else begin
      error <= 1'b0;
      if (frame_start) begin
        seen <= '0;
      end else begin
        case (state)
          COLLECT: begin
            if (accept) begin
              case (corner_id)
                2'd0: begin top_left_x  <= corner_x; top_left_y  <= corner_y; end
                2'd1: begin top_right_x <= corner_x; top_right_y <= corner_y; end
                2'd2: begin bot_left_x  <= corner_x; bot_left_y  <= corner_y; end
                default: begin bot_right_x <= corner_x; bot_right_y <= corner_y; end
              endcase
              seen <= seen | id_onehot;
              if (corners_complete) settle_cnt <= c_settle_load;
            end
          end
          SETTLE: begin
            settle_cnt <= settle_cnt - c_cnt_w'(1);
            if (settle_final) begin
              box_sx    <= draw_start_x;
              box_sy    <= draw_start_y;
              box_ex    <= draw_end_x;
              box_ey    <= draw_end_y;
              box_scale <= scale;
            end
          end
          CHECK: begin
            if (reject) begin
              error <= 1'b1;
              seen  <= '0;
            end else begin
              pix_x_q <= box_sx;
              pix_y_q <= box_sy;
              acc_x   <= '0;
              acc_y   <= '0;
            end
          end
          SCAN: begin
            if (pix.pix_ready && !last_pix) begin
              if (pix_x_q != box_ex) begin
                pix_x_q <= pix_x_q + 11'd1;
                acc_x   <= acc_x + {10'd0, box_scale};
              end else begin
                pix_x_q <= box_sx;
                acc_x   <= '0;
                pix_y_q <= pix_y_q + 11'd1;
                acc_y   <= acc_y + {10'd0, box_scale};
              end
            end
          end
          DONE:    seen <= '0;
          default: ;
        endcase
      end
    end
  end

endmodule
